systolic_mac_engine: RTL and testbench
======================================

# systolic_mac_engine

Parametrised weight-stationary systolic MAC array with handshaked weight loading, streamed activation vectors, built-in input skew and output de-skew, and backpressure-aware stalling. Each accepted activation vector a[0..ROWS-1] yields one aligned output vector p[j] = Σ_i a[i]·W[i][j]. It replaces the fixed square array in the accelerator datapath: a tile loader feeds it upstream, and the accumulation/writeback stage consumes it downstream.

## Interface
- DATA_WIDTH, 8: signed weight/activation width
- ROWS, 4: array rows; activation vector length
- COLS, 4: array columns; output vector length
- ACCUM_WIDTH, 32: signed partial-sum width; must be ≥ 2·DATA_WIDTH + clog2(ROWS)

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- w_valid  in  1  weight row beat valid
- w_ready  out  1  weight row accepted when w_valid & w_ready
- w_data  in  COLS·DATA_WIDTH  one weight row; column j at bits [j·DATA_WIDTH +: DATA_WIDTH]
- a_valid  in  1  activation vector valid
- a_ready  out  1  activation accepted when a_valid & a_ready
- a_data  in  ROWS·DATA_WIDTH  activation vector; row i at [i·DATA_WIDTH +: DATA_WIDTH]
- a_last  in  1  marks the final vector of a tile; sampled with the a handshake
- p_valid  out  1  output vector valid
- p_ready  in  1  downstream accepts p_data
- p_data  out  COLS·ACCUM_WIDTH  output vector; column j at [j·ACCUM_WIDTH +: ACCUM_WIDTH]
- p_last  out  1  accompanies the output vector derived from the a_last vector
- busy  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: w_ready=1, a_ready=0. A w handshake writes row 0 and moves to LOAD_W with row counter = 1.
- LOAD_W: w_ready=1. Each handshake writes row[counter], then counter increments. After row ROWS-1 is written, go to STREAM. No rows are skipped.
- STREAM: a_ready = ~stall, w_ready=0. An accepted vector enters the skew pipeline; row i is delayed i cycles. A handshake with a_last=1 moves to DRAIN. The next cycle, a_ready=0.
- DRAIN: a_ready=0. The pipeline flushes. Once the last output (p_last) completes its handshake, go to STREAM if weights are retained, else IDLE. Weights are retained.
- In STREAM with the pipeline empty, w_valid=1 and a_valid=0: go to LOAD_W to reload weights. a_valid has priority over w_valid on the same cycle.
- Arithmetic:
  - Product is DATA_WIDTH×DATA_WIDTH signed → 2·DATA_WIDTH bits, sign-extended to ACCUM_WIDTH.
  - PE(i,j): psum_out = psum_in + W[i][j]·act, where psum_in = 0 for row 0.
  - Additions wrap in two's complement. The parameter rule guarantees no overflow.
- A valid bit travels with every data token through the skew, array and de-skew stages. Bubbles (a_valid=0) propagate as invalid tokens and never produce p_valid.
- Stall: stall = p_valid & ~p_ready. While stall=1, every pipeline register, including skew and de-skew, holds. a_ready=0.
- p_data and p_last are stable while p_valid=1 & p_ready=0.
- Reset (rst_n=0 at a rising edge), applied at any point including mid-stream:
  - FSM → IDLE, all weights → 0, all pipeline and valid bits → 0.
  - Outputs: w_ready=1, a_ready=0, p_valid=0, p_data=0, p_last=0, busy=0.

## Timing
- Latency L = ROWS + COLS cycles, from the a handshake edge to the first edge where p_valid=1, with no stalls. L = 8 for 4×4.
- Throughput is one vector per cycle when p_ready stays high.
- Each stall cycle adds exactly one cycle to the latency of every in-flight token.
- A weight row written on cycle t is usable by a vector accepted at t+1 or later.
- DRAIN lasts L cycles after the last handshake plus any stall cycles.
- w_ready and a_ready are registered or derived only from state and stall. Neither depends combinationally on w_valid or a_valid.

## Structure
- Shared package systolic_pkg: state enum (IDLE, LOAD_W, STREAM, DRAIN) and a clog2-based counter-width helper.
- Sub-module systolic_pe: one weight register, activation pass-right register, psum pass-down register, valid bit, and enable input.
- Top: FSM, row counter, input skew triangle, output de-skew triangle (column j delayed COLS-1-j), and stall logic.

## Test plan
- Identity load: W = I (4×4), stream a = {1,2,3,4} → p = {1,2,3,4} at exactly 8 cycles after the handshake; busy=1.
- Signed extremes: all W = −128, a = {−128 ×4} → every p[j] = 65536; a = {127 ×4} → p[j] = −65024.
- Back-to-back: 16 vectors, one per cycle with p_ready=1 → 16 consecutive p_valid cycles in order; p_last only on the 16th.
- Backpressure: p_ready toggles 0/1 pseudo-randomly over 32 vectors → no loss or duplication; p_data stays stable while stalled; a_ready=0 during stalls.
- Bubbles and reload: a_valid gaps on alternate cycles → matching p_valid gaps. After DRAIN, load new W = 2·I → the next vector {1,2,3,4} gives {2,4,6,8}.
- Reset mid-stream: rst_n=0 for one cycle with 5 tokens in flight → next cycle p_valid=0, w_ready=1, a_ready=0; stale outputs never appear.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and width helper for the systolic MAC engine
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - weight-stationary processing element with pass-right activation and pass-down psum
module systolic_pe #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   w_we,
    input  logic [DATA_WIDTH-1:0]  w_in,
    input  logic [DATA_WIDTH-1:0]  act_in,
    input  logic [ACCUM_WIDTH-1:0] psum_in,
    input  logic                   v_in,
    output logic [DATA_WIDTH-1:0]  act_out,
    output logic [ACCUM_WIDTH-1:0] psum_out,
    output logic                   v_out
);

    logic signed [DATA_WIDTH-1:0]   w_q;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = w_q * $signed(act_in);

    // Weight loads are independent of the stall; the data path advances only when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q      <= '0;
            act_out  <= '0;
            psum_out <= '0;
            v_out    <= 1'b0;
        end else begin
            if (w_we) begin
                w_q <= w_in;
            end
            if (en) begin
                act_out  <= act_in;
                psum_out <= psum_in + ACCUM_WIDTH'(prod);
                v_out    <= v_in;
            end
        end
    end

endmodule

// File: rtl/systolic_mac_engine.sv
// rtl/systolic_mac_engine.sv - weight-stationary systolic MAC array with skew, de-skew and stall control
module systolic_mac_engine
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [COLS*DATA_WIDTH-1:0]  w_data,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]  a_data,
    input  logic                        a_last,
    output logic                        p_valid,
    input  logic                        p_ready,
    output logic [COLS*ACCUM_WIDTH-1:0] p_data,
    output logic                        p_last,
    output logic                        busy
);

    localparam int LAT = ROWS + COLS;
    localparam int RW  = cnt_width(ROWS);
    localparam int FW  = cnt_width(LAT + 2);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t          state, state_next;
    logic [RW-1:0]   row_cnt;
    logic [FW-1:0]   inflight;
    logic            stall, w_hs, a_hs, p_hs;
    logic [LAT:0]    last_sr;
    logic [COLS-1:0] col_v;

    logic [DATA_WIDTH-1:0]  act_h  [ROWS][COLS+1];
    logic                   v_h    [ROWS][COLS+1];
    logic [ACCUM_WIDTH-1:0] psum_v [ROWS+1][COLS];

    assign stall = p_valid & ~p_ready;
    assign w_hs  = w_valid & w_ready;
    assign a_hs  = a_valid & a_ready;
    assign p_hs  = p_valid & p_ready;
    assign busy  = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake readies; readies depend only on state and stall.
    always_comb begin
        state_next = state;
        w_ready    = 1'b0;
        a_ready    = 1'b0;
        unique case (state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    state_next = (ROWS == 1) ? STREAM : LOAD_W;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && row_cnt == LAST_ROW) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                a_ready = ~stall;
                if (a_valid) begin
                    if (!stall && a_last) begin
                        state_next = DRAIN;
                    end
                end else if (w_valid && inflight == '0) begin
                    state_next = LOAD_W;
                end
            end
            DRAIN: begin
                if (p_hs && p_last) begin
                    state_next = STREAM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Row pointer for weight loading; parked at zero outside LOAD_W so a reload starts at row 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt <= '0;
        end else if (w_hs) begin
            row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
        end else if (state != LOAD_W) begin
            row_cnt <= '0;
        end
    end

    // Tokens accepted but not yet delivered; zero means the whole pipeline is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + FW'(a_hs) - FW'(p_hs);
        end
    end

    // Last flag rides a shift register matched to the full data path depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_sr <= '0;
        end else if (!stall) begin
            last_sr <= {last_sr[LAT-1:0], a_hs & a_last};
        end
    end

    assign p_last = last_sr[LAT];

    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        logic [DATA_WIDTH-1:0] d [i+1];
        logic                  v [i+1];
        logic                  unused_east;

        // Input capture plus i delay stages so row i meets its diagonal wavefront.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) begin
                    d[k] <= '0;
                    v[k] <= 1'b0;
                end
            end else if (!stall) begin
                d[0] <= a_data[i*DATA_WIDTH +: DATA_WIDTH];
                v[0] <= a_hs;
                for (int k = 1; k <= i; k++) begin
                    d[k] <= d[k-1];
                    v[k] <= v[k-1];
                end
            end
        end

        assign act_h[i][0] = d[i];
        assign v_h[i][0]   = v[i];
        assign unused_east = ^{act_h[i][COLS], v_h[i][COLS]};
    end

    for (genvar j = 0; j < COLS; j++) begin : g_top_psum
        assign psum_v[0][j] = '0;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACCUM_WIDTH(ACCUM_WIDTH)
            ) u_pe (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (~stall),
                .w_we    (w_hs && row_cnt == RW'(i)),
                .w_in    (w_data[j*DATA_WIDTH +: DATA_WIDTH]),
                .act_in  (act_h[i][j]),
                .psum_in (psum_v[i][j]),
                .v_in    (v_h[i][j]),
                .act_out (act_h[i][j+1]),
                .psum_out(psum_v[i+1][j]),
                .v_out   (v_h[i][j+1])
            );
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_deskew
        localparam int DEPTH = COLS - j;
        logic [ACCUM_WIDTH-1:0] d [DEPTH];
        logic                   v [DEPTH];

        // Column j trails column 0 by j cycles, so it gets j fewer stages; the last stage is the output register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    d[k] <= '0;
                    v[k] <= 1'b0;
                end
            end else if (!stall) begin
                d[0] <= psum_v[ROWS][j];
                v[0] <= v_h[ROWS-1][j+1];
                for (int k = 1; k < DEPTH; k++) begin
                    d[k] <= d[k-1];
                    v[k] <= v[k-1];
                end
            end
        end

        assign p_data[j*ACCUM_WIDTH +: ACCUM_WIDTH] = d[DEPTH-1];
        assign col_v[j] = v[DEPTH-1];
    end

    assign p_valid = &col_v;

endmodule

// File: tb/tb_systolic_mac_engine.sv
// tb/tb_systolic_mac_engine.sv - scoreboard bench for systolic_mac_engine
module tb_systolic_mac_engine;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 32;
    localparam int L  = R + C;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [C*DW-1:0] w_data = '0;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic [R*DW-1:0] a_data = '0;
    logic            a_last = 1'b0;
    logic            p_valid;
    logic            p_ready = 1'b1;
    logic [C*AW-1:0] p_data;
    logic            p_last;
    logic            busy;

    always #5 clk = ~clk;

    systolic_mac_engine #(
        .DATA_WIDTH (DW),
        .ROWS       (R),
        .COLS       (C),
        .ACCUM_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_data (w_data),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_data (a_data),
        .a_last (a_last),
        .p_valid(p_valid),
        .p_ready(p_ready),
        .p_data (p_data),
        .p_last (p_last),
        .busy   (busy)
    );

    typedef struct {
        logic [C*AW-1:0] data;
        logic            last;
    } exp_t;

    exp_t sb[$];
    int   wm [R][C];
    int   n_checks = 0;
    int   n_err = 0;
    int   out_cnt = 0;
    int   cur_run = 0;
    int   max_run = 0;
    bit   mon_en = 0;
    bit   mon_clr = 0;
    bit   bp_en = 0;
    logic            prev_stall = 1'b0;
    logic [C*AW-1:0] prev_data = '0;
    logic            prev_last = 1'b0;

    task automatic chk(input string tag, input logic [C*AW-1:0] got, input logic [C*AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [C*AW-1:0] model(input logic [R*DW-1:0] v);
        logic [C*AW-1:0] res;
        res = '0;
        for (int j = 0; j < C; j++) begin
            int s;
            s = 0;
            for (int i = 0; i < R; i++) begin
                s += int'($signed(v[i*DW +: DW])) * wm[i][j];
            end
            res[j*AW +: AW] = s;
        end
        return res;
    endfunction

    // Output-side scoreboard, stall-hold and readiness checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_clr) begin
            cur_run = 0;
            max_run = 0;
        end else if (mon_en && rst_n) begin
            exp_t e;
            if (prev_stall && p_valid) begin
                chk("hold_data", p_data, prev_data);
                chk("hold_last", p_last, prev_last);
            end
            if (p_valid && !p_ready) chk("a_ready_stall", a_ready, 0);
            if (p_valid && p_ready) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("p_data", p_data, e.data);
                    chk("p_last", p_last, e.last);
                end
                out_cnt++;
            end
            cur_run = p_valid ? cur_run + 1 : 0;
            if (cur_run > max_run) max_run = cur_run;
            prev_stall = p_valid & !p_ready;
            prev_data  = p_data;
            prev_last  = p_last;
        end
    end

    // Downstream readiness: random when backpressure is enabled, else always ready.
    always @(posedge clk) begin
        #1;
        p_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic load_w();
        for (int i = 0; i < R; i++) begin
            bit ok;
            ok = 0;
            w_valid = 1'b1;
            for (int j = 0; j < C; j++) w_data[j*DW +: DW] = 8'(wm[i][j]);
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (w_ready) begin
                    ok = 1;
                    break;
                end
            end
            chk("w_accept", ok, 1);
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [R*DW-1:0] v, input bit last);
        bit ok;
        ok = 0;
        a_valid = 1'b1;
        a_data  = v;
        a_last  = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (a_ready) begin
                ok = 1;
                break;
            end
        end
        chk("a_accept", ok, 1);
        if (ok) sb.push_back('{data: model(v), last: last});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1;
        @(negedge clk);
        #1;
        mon_clr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_diag(input int d);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) wm[i][j] = (i == j) ? d : 0;
    endtask

    initial begin
        int cyc;
        int base;
        int bad;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_w_ready", w_ready, 1);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_p_valid", p_valid, 0);
        chk("rst_p_data", p_data, 0);
        chk("rst_p_last", p_last, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1;

        // Identity weights and latency.
        set_diag(1);
        load_w();
        chk("busy_stream", busy, 1);
        send_a(32'h04030201, 1);
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (p_valid) break;
        end
        chk("latency", cyc, L);
        wait_drain();

        // Signed extremes.
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) wm[i][j] = -128;
        load_w();
        send_a(32'h80808080, 0);
        send_a(32'h7f7f7f7f, 1);
        wait_drain();

        // Back-to-back with random weights.
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) wm[i][j] = int'($urandom_range(0, 255)) - 128;
        load_w();
        clr_mon();
        base = out_cnt;
        for (int k = 0; k < 16; k++) send_a($urandom, k == 15);
        wait_drain();
        chk("b2b_count", out_cnt - base, 16);
        chk("b2b_run", max_run, 16);

        // Random backpressure.
        bp_en = 1;
        base  = out_cnt;
        for (int k = 0; k < 32; k++) send_a($urandom, k == 31);
        wait_drain();
        bp_en = 0;
        @(posedge clk);
        #1;
        chk("bp_count", out_cnt - base, 32);

        // Bubbles on alternate cycles.
        clr_mon();
        base = out_cnt;
        for (int k = 0; k < 8; k++) begin
            send_a($urandom, k == 7);
            if (k < 7) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        chk("bubble_count", out_cnt - base, 8);
        chk("bubble_run", max_run, 1);

        // Reload with 2*I.
        set_diag(2);
        load_w();
        send_a(32'h04030201, 1);
        wait_drain();

        // Reset with tokens in flight.
        for (int k = 0; k < 5; k++) send_a($urandom, 0);
        mon_en = 0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_p_valid", p_valid, 0);
        chk("mid_rst_w_ready", w_ready, 1);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_p_data", p_data, 0);
        bad = 0;
        repeat (2 * L) begin
            @(negedge clk);
            if (p_valid) bad++;
        end
        chk("stale_out", bad, 0);

        // Recovery after reset.
        @(posedge clk);
        #1;
        mon_en = 1;
        set_diag(1);
        load_w();
        send_a($urandom, 1);
        wait_drain();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
